fib_lanes_gen: RTL and testbench

Parametrised Fibonacci-sequence generator that emits `LANES` consecutive terms per output beat from software-loaded seeds.
- Streams into downstream consumers over a valid/ready handshake.
- Supports an optional programmed beat count and optional overflow-terminated runs.
- Successor to the single- and double-rate fixed-width generators: adds width and lane parameters, seeds, flow control and run termination.

---
 rtl/fib_lanes_gen_pkg.sv | 25 ++
 rtl/fib_lanes_gen_chain.sv | 26 ++
 rtl/fib_lanes_gen.sv | 134 +++++++++++++
 tb/tb_fib_lanes_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_lanes_gen_pkg.sv
// Shared types and helpers for the multi-lane Fibonacci generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fib_state_e;

  localparam int FIB_MAX_LANES = 8;

  // Thermometer mask: bit i set once any term at index <= i has carried out.
  function automatic logic [FIB_MAX_LANES+1:0] fib_lane_ovf(input logic [FIB_MAX_LANES+1:0] carry);
    logic [FIB_MAX_LANES+1:0] mask;
    logic                     seen;
    mask = '0;
    seen = 1'b0;
    for (int i = 0; i < FIB_MAX_LANES + 2; i++) begin
      seen    = seen | carry[i];
      mask[i] = seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/fib_lanes_gen_chain.sv
// Combinational Fibonacci chain: LANES+2 terms from (a, b) with per-term carry-out flags.
module fib_lane_chain #(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic [W-1:0]              a,
  input  logic [W-1:0]              b,
  output logic [LANES+1:0][W-1:0]   t,
  output logic [LANES+1:0]          carry
);

  always_comb begin
    logic [W:0] sum;
    sum   = '0;
    t     = '0;
    carry = '0;
    t[0]  = a;
    t[1]  = b;
    for (int i = 2; i < LANES + 2; i++) begin
      sum      = {1'b0, t[i-1]} + {1'b0, t[i-2]};
      t[i]     = sum[W-1:0];
      carry[i] = sum[W];
    end
  end

endmodule

// File: rtl/fib_lanes_gen.sv
// fib_lanes_gen: LANES Fibonacci terms per beat from loaded seeds; FIB_OVF_STOP_EN ends runs on carry-out.
// Latency: first beat one cycle after start, then one beat per cycle.
// Backpressure: beat held stable while out_valid && !out_ready.
module fib_lanes_gen
  import fib_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         seed_a,
  input  logic [W-1:0]         seed_b,
  input  logic [CNT_W-1:0]     beats,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_lane_vld,
  output logic                 out_last,
  output logic                 ovf,
  output logic                 busy
);

  fib_state_e              state;
  logic [W-1:0]            a, b;
  logic [CNT_W-1:0]        cnt;

  logic [W-1:0]            chain_a, chain_b;
  logic [LANES+1:0][W-1:0] t;
  logic [LANES+1:0]        carry;
  logic [LANES*W-1:0]      beat_dat;
  logic [LANES-1:0]        lane_vld;
  logic                    ovf_hit;
  logic                    fin_cnt;
  logic                    stop_now;

  // One chain serves both paths: seeds on a load, the a/b registers otherwise.
  assign chain_a = start ? seed_a : a;
  assign chain_b = start ? seed_b : b;

  fib_lane_chain #(
    .W     (W),
    .LANES (LANES)
  ) u_chain (
    .a     (chain_a),
    .b     (chain_b),
    .t     (t),
    .carry (carry)
  );

  assign beat_dat = t[LANES-1:0];

`ifdef FIB_OVF_STOP_EN
  logic [FIB_MAX_LANES+1:0] carry_ext;
  logic [FIB_MAX_LANES+1:0] ovf_mask;
  logic                     unused_mask;

  always_comb begin
    carry_ext              = '0;
    carry_ext[LANES+1:0]   = carry;
  end

  assign ovf_mask    = fib_lane_ovf(carry_ext);
  assign lane_vld    = ~ovf_mask[LANES-1:0];
  assign ovf_hit     = |carry;
  assign unused_mask = ^ovf_mask[FIB_MAX_LANES+1:LANES];
`else
  logic unused_carry;

  assign unused_carry = ^carry;
  assign lane_vld     = '1;
  assign ovf_hit      = 1'b0;
`endif

  // cnt holds beats still to present including the one on the bus; 0 = unbounded.
  assign fin_cnt  = start ? (beats == CNT_W'(1)) : (cnt == CNT_W'(2));
  assign stop_now = fin_cnt | ovf_hit;

  assign busy      = (state != IDLE);
  assign out_valid = busy;

`ifdef FIB_OVF_STOP_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      cnt          <= '0;
      out_data     <= '0;
      out_lane_vld <= '0;
      out_last     <= 1'b0;
`ifdef FIB_OVF_STOP_EN
      ovf_q        <= 1'b0;
`endif
    end else if (start) begin
      out_data     <= beat_dat;
      out_lane_vld <= lane_vld;
      out_last     <= stop_now;
      a            <= t[LANES];
      b            <= t[LANES+1];
      cnt          <= beats;
      state        <= stop_now ? DRAIN : RUN;
`ifdef FIB_OVF_STOP_EN
      ovf_q        <= ovf_hit;
`endif
    end else if (out_valid && out_ready) begin
      if (state == DRAIN) begin
        state        <= IDLE;
        out_lane_vld <= '0;
        out_last     <= 1'b0;
      end else begin
        out_data     <= beat_dat;
        out_lane_vld <= lane_vld;
        out_last     <= stop_now;
        a            <= t[LANES];
        b            <= t[LANES+1];
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
        state        <= stop_now ? DRAIN : RUN;
`ifdef FIB_OVF_STOP_EN
        ovf_q        <= ovf_q | ovf_hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fib_lanes_gen.sv
// Directed bench for fib_lanes_gen across (W,LANES) = (16,2), (16,4), (8,2).
module tb_fib_lanes_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // u0: W=16 LANES=2
  logic        s0 = 1'b0, r0 = 1'b0;
  logic [15:0] sa0 = '0, sb0 = '0, bt0 = '0;
  logic        v0, l0, o0, bz0;
  logic [31:0] d0;
  logic [1:0]  lv0;
  // u1: W=16 LANES=4
  logic        s1 = 1'b0, r1 = 1'b0;
  logic [15:0] sa1 = '0, sb1 = '0, bt1 = '0;
  logic        v1, l1, o1, bz1;
  logic [63:0] d1;
  logic [3:0]  lv1;
  // u2: W=8 LANES=2
  logic        s2 = 1'b0, r2 = 1'b0;
  logic [7:0]  sa2 = '0, sb2 = '0;
  logic [15:0] bt2 = '0;
  logic        v2, l2, o2, bz2;
  logic [15:0] d2;
  logic [1:0]  lv2;

  fib_lanes_gen #(.W(16), .LANES(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .start(s0), .seed_a(sa0), .seed_b(sb0), .beats(bt0),
    .out_valid(v0), .out_ready(r0), .out_data(d0), .out_lane_vld(lv0),
    .out_last(l0), .ovf(o0), .busy(bz0));

  fib_lanes_gen #(.W(16), .LANES(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(s1), .seed_a(sa1), .seed_b(sb1), .beats(bt1),
    .out_valid(v1), .out_ready(r1), .out_data(d1), .out_lane_vld(lv1),
    .out_last(l1), .ovf(o1), .busy(bz1));

  fib_lanes_gen #(.W(8), .LANES(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(s2), .seed_a(sa2), .seed_b(sb2), .beats(bt2),
    .out_valid(v2), .out_ready(r2), .out_data(d2), .out_lane_vld(lv2),
    .out_last(l2), .ovf(o2), .busy(bz2));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [15:0] sa;
    logic [15:0] sb;
    logic [15:0] bt;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  elv;
    logic        el;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    // Inputs applied for one cycle; expectations observed on the following negedge.
    tbl[0]  = '{1'b1, 16'd1, 16'd1, 16'd3, 1'b1, 1'b1, 32'h0001_0001, 2'b11, 1'b0};
    tbl[1]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 32'h0003_0002, 2'b11, 1'b0};
    tbl[2]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 32'h0008_0005, 2'b11, 1'b1};
    tbl[3]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0};
    tbl[4]  = '{1'b1, 16'd1, 16'd1, 16'd3, 1'b0, 1'b1, 32'h0001_0001, 2'b11, 1'b0};
    tbl[5]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 32'h0003_0002, 2'b11, 1'b0};
    tbl[6]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 32'h0003_0002, 2'b11, 1'b0};
    tbl[7]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 32'h0003_0002, 2'b11, 1'b0};
    tbl[8]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 32'h0008_0005, 2'b11, 1'b1};
    tbl[9]  = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0};
    tbl[10] = '{1'b1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1, 32'h0001_0001, 2'b11, 1'b0};
    tbl[11] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 32'h0003_0002, 2'b11, 1'b0};
    tbl[12] = '{1'b1, 16'd3, 16'd5, 16'd0, 1'b1, 1'b1, 32'h0005_0003, 2'b11, 1'b0};
    tbl[13] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 32'h000D_0008, 2'b11, 1'b0};
    tbl[14] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 32'h000D_0008, 2'b11, 1'b0};
    tbl[15] = '{1'b1, 16'd2, 16'd3, 16'd1, 1'b0, 1'b1, 32'h0003_0002, 2'b11, 1'b1};
    tbl[16] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 32'h0,        2'b00, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_u0_valid", {63'd0, v0}, 64'd0);
    chk("rst_u0_data", {32'd0, d0}, 64'd0);
    chk("rst_u0_lane_vld", {62'd0, lv0}, 64'd0);
    chk("rst_u0_last", {63'd0, l0}, 64'd0);
    chk("rst_u0_busy", {63'd0, bz0}, 64'd0);
    chk("rst_u0_ovf", {63'd0, o0}, 64'd0);
    chk("rst_u1_data", d1, 64'd0);
    chk("rst_u2_valid", {63'd0, v2}, 64'd0);
    rst = 1'b1;

    // Table-driven single-beat steps on u0
    for (int i = 0; i < NV; i++) begin
      s0 = tbl[i].st; sa0 = tbl[i].sa; sb0 = tbl[i].sb; bt0 = tbl[i].bt; r0 = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {63'd0, v0}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_busy", i), {63'd0, bz0}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ovf", i), {63'd0, o0}, 64'd0);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), {32'd0, d0}, {32'd0, tbl[i].ed});
        chk($sformatf("vec%0d_lane_vld", i), {62'd0, lv0}, {62'd0, tbl[i].elv});
        chk($sformatf("vec%0d_last", i), {63'd0, l0}, {63'd0, tbl[i].el});
      end
    end
    s0 = 1'b0; r0 = 1'b0;

    // u1: LANES=4 unbounded run from seeds 1,2 through the 16-bit overflow point
    s1 = 1'b1; sa1 = 16'd1; sb1 = 16'd2; bt1 = 16'd0; r1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    chk("u1_b1_data", d1, {16'd5, 16'd3, 16'd2, 16'd1});
    repeat (4) @(negedge clk);
    chk("u1_b5_data", d1, {16'd10946, 16'd6765, 16'd4181, 16'd2584});
    chk("u1_b5_last", {63'd0, l1}, 64'd0);
    chk("u1_b5_ovf", {63'd0, o1}, 64'd0);
    @(negedge clk);
    chk("u1_b6_valid", {63'd0, v1}, 64'd1);
    chk("u1_b6_lanes012", {16'd0, d1[47:0]}, {16'd0, 16'd46368, 16'd28657, 16'd17711});
`ifdef FIB_OVF_STOP_EN
    chk("u1_b6_lane_vld", {60'd0, lv1}, 64'h7);
    chk("u1_b6_last", {63'd0, l1}, 64'd1);
    chk("u1_b6_ovf", {63'd0, o1}, 64'd1);
    @(negedge clk);
    chk("u1_end_valid", {63'd0, v1}, 64'd0);
    chk("u1_end_busy", {63'd0, bz1}, 64'd0);
    chk("u1_end_ovf_sticky", {63'd0, o1}, 64'd1);
`else
    chk("u1_b6_lane3_wrap", {48'd0, d1[63:48]}, 64'd9489);
    chk("u1_b6_lane_vld", {60'd0, lv1}, 64'hF);
    chk("u1_b6_last", {63'd0, l1}, 64'd0);
    chk("u1_b6_ovf", {63'd0, o1}, 64'd0);
    @(negedge clk);
    chk("u1_b7_data", d1, {16'd55477, 16'd55667, 16'd65346, 16'd55857});
    chk("u1_b7_valid", {63'd0, v1}, 64'd1);
`endif
    r1 = 1'b0;

    // u2: W=8 seeds 144,233, two beats
    s2 = 1'b1; sa2 = 8'd144; sb2 = 8'd233; bt2 = 16'd2; r2 = 1'b1;
    @(negedge clk);
    s2 = 1'b0;
    chk("u2_b1_data", {48'd0, d2}, {48'd0, 8'd233, 8'd144});
    chk("u2_b1_lane_vld", {62'd0, lv2}, 64'h3);
`ifdef FIB_OVF_STOP_EN
    chk("u2_b1_last", {63'd0, l2}, 64'd1);
    chk("u2_b1_ovf", {63'd0, o2}, 64'd1);
`else
    chk("u2_b1_last", {63'd0, l2}, 64'd0);
    chk("u2_b1_ovf", {63'd0, o2}, 64'd0);
    @(negedge clk);
    chk("u2_b2_data", {48'd0, d2}, {48'd0, 8'd98, 8'd121});
    chk("u2_b2_last", {63'd0, l2}, 64'd1);
    chk("u2_b2_ovf", {63'd0, o2}, 64'd0);
`endif
    @(negedge clk);
    chk("u2_end_valid", {63'd0, v2}, 64'd0);
    chk("u2_end_busy", {63'd0, bz2}, 64'd0);
    r2 = 1'b0;

    // Reset mid-run on u0, with a start strobe during reset that must be ignored
    s0 = 1'b1; sa0 = 16'd1; sb0 = 16'd1; bt0 = 16'd0; r0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    @(negedge clk);
    chk("mid_pre_rst_data", {32'd0, d0}, {32'd0, 32'h0003_0002});
    rst = 1'b0; s0 = 1'b1; sa0 = 16'd7; sb0 = 16'd7; bt0 = 16'd0;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, v0}, 64'd0);
    chk("mid_rst_data", {32'd0, d0}, 64'd0);
    chk("mid_rst_lane_vld", {62'd0, lv0}, 64'd0);
    chk("mid_rst_last", {63'd0, l0}, 64'd0);
    chk("mid_rst_busy", {63'd0, bz0}, 64'd0);
    rst = 1'b1; s0 = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {63'd0, v0}, 64'd0);
    s0 = 1'b1; sa0 = 16'd1; sb0 = 16'd1; bt0 = 16'd2;
    @(negedge clk);
    s0 = 1'b0;
    chk("restart_b1_data", {32'd0, d0}, {32'd0, 32'h0001_0001});
    chk("restart_b1_last", {63'd0, l0}, 64'd0);
    @(negedge clk);
    chk("restart_b2_data", {32'd0, d0}, {32'd0, 32'h0003_0002});
    chk("restart_b2_last", {63'd0, l0}, 64'd1);
    @(negedge clk);
    chk("restart_end_valid", {63'd0, v0}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
